test_status_unit: RTL and testbench

//  Memory-mapped responder inside soc for the self-checking test end/pass/testnum protocol.

---
 rtl/test_status_unit_if.sv | 19 +
 rtl/test_status_unit.sv | 141 ++++++++++++++
 tb/tb_test_status_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/test_status_unit_if.sv
// rtl/test_status_unit_if.sv - single-cycle register bus between the test program and the status unit
interface test_status_unit_if;
    logic        req_i;
    logic        we_i;
    logic [63:0] addr_i;
    logic [63:0] wdata_i;
    logic [63:0] rdata_o;
    logic        rvalid_o;

    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  rdata_o, rvalid_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output rdata_o, rvalid_o
    );
endinterface

// File: rtl/test_status_unit.sv
// rtl/test_status_unit.sv - test number / result latch with watchdog and sticky done/pass/timeout
module test_status_unit #(
    parameter logic [63:0] BASE_ADDR      = 64'h0000_0000_1000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    test_status_unit_if.slave    bus,
    output logic                 done_o,
    output logic                 pass_o,
    output logic                 timeout_o,
    output logic [63:0]          testnum_o,
    output logic [63:0]          cycle_cnt_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    localparam logic [1:0]  REG_TESTNUM = 2'd0;
    localparam logic [1:0]  REG_RESULT  = 2'd1;
    localparam logic [1:0]  REG_CYCLES  = 2'd2;
    localparam logic [1:0]  REG_STATUS  = 2'd3;
    localparam bit          WD_EN       = (TIMEOUT_CYCLES != 0);
    localparam logic [63:0] WD_LAST     = 64'(TIMEOUT_CYCLES) - 64'd1;

    state_t      state_q, state_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        timeout_q, timeout_d;
    logic [63:0] testnum_q, testnum_d;
    logic [63:0] cnt_q, cnt_d;
    logic [63:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;

    logic        in_range;
    logic [1:0]  reg_sel;
    logic        wr_en;
    logic        rd_en;
    logic        result_wr;
    logic        expire;
    logic [63:0] rd_mux;
    logic        unused_addr_lsb;

    // Byte offset within a doubleword is irrelevant: every access is 64 bits wide.
    assign unused_addr_lsb = ^bus.addr_i[2:0];

    assign in_range  = (bus.addr_i[63:5] == BASE_ADDR[63:5]);
    assign reg_sel   = bus.addr_i[4:3];
    assign wr_en     = bus.req_i & bus.we_i & in_range;
    assign rd_en     = bus.req_i & ~bus.we_i;
    assign result_wr = wr_en && (reg_sel == REG_RESULT) && (state_q == ST_RUN);
    assign expire    = WD_EN && (state_q == ST_RUN) && (cnt_q == WD_LAST);

    always_comb begin
        rd_mux = 64'd0;
        case (reg_sel)
            REG_TESTNUM: rd_mux = testnum_q;
            REG_RESULT:  rd_mux = 64'd0;
            REG_CYCLES:  rd_mux = cnt_q;
            REG_STATUS:  rd_mux = {59'd0, timeout_q, pass_q, done_q, state_q};
            default:     rd_mux = 64'd0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        pass_d    = pass_q;
        timeout_d = timeout_q;
        testnum_d = testnum_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rvalid_d  = rd_en;

        if (rd_en) begin
            rdata_d = in_range ? rd_mux : 64'd0;
        end

        if (wr_en && (reg_sel == REG_TESTNUM) &&
            ((state_q == ST_IDLE) || (state_q == ST_RUN))) begin
            testnum_d = bus.wdata_i;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 64'd1;
                end
                // A result landing on the expiry edge takes priority over the watchdog.
                if (result_wr) begin
                    state_d = bus.wdata_i[0] ? ST_PASS : ST_FAIL;
                    done_d  = 1'b1;
                    pass_d  = bus.wdata_i[0];
                end else if (expire) begin
                    state_d   = ST_FAIL;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
            testnum_q <= 64'd0;
            cnt_q     <= 64'd0;
            rdata_q   <= 64'd0;
            rvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            timeout_q <= timeout_d;
            testnum_q <= testnum_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
        end
    end

    assign bus.rdata_o  = rdata_q;
    assign bus.rvalid_o = rvalid_q;
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign timeout_o    = timeout_q;
    assign testnum_o    = testnum_q;
    assign cycle_cnt_o  = cnt_q;
endmodule

// File: tb/tb_test_status_unit.sv
// tb/tb_test_status_unit.sv - directed vector bench for test_status_unit
module tb_test_status_unit;
    localparam logic [63:0] B   = 64'h0000_0000_1000_0000;
    localparam logic [63:0] TN  = B;
    localparam logic [63:0] RES = B + 64'h08;
    localparam logic [63:0] CYC = B + 64'h10;
    localparam logic [63:0] ST  = B + 64'h18;

    logic        clk;
    logic        rst;
    logic        done_o, pass_o, timeout_o;
    logic [63:0] testnum_o, cycle_cnt_o;

    int checks = 0;
    int errors = 0;

    test_status_unit_if bus ();

    test_status_unit #(
        .BASE_ADDR      (B),
        .TIMEOUT_CYCLES (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .timeout_o   (timeout_o),
        .testnum_o   (testnum_o),
        .cycle_cnt_o (cycle_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        rvalid;
        logic [63:0] rdata;
        logic        done;
        logic        pass;
        logic        tmo;
        logic [63:0] tn;
        logic [63:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic req, logic we, logic [63:0] addr, logic [63:0] wdata,
                                logic rvalid, logic [63:0] rdata, logic done, logic pass,
                                logic tmo, logic [63:0] tn, logic [63:0] cnt);
        vec_t v;
        v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.rvalid = rvalid; v.rdata = rdata; v.done = done; v.pass = pass;
        v.tmo = tmo; v.tn = tn; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic rv, input logic [63:0] rd,
                           input logic d, input logic p, input logic t,
                           input logic [63:0] tn, input logic [63:0] cnt);
        chk({tag, ".rvalid"},  64'(bus.rvalid_o), 64'(rv));
        chk({tag, ".rdata"},   bus.rdata_o,       rd);
        chk({tag, ".done"},    64'(done_o),       64'(d));
        chk({tag, ".pass"},    64'(pass_o),       64'(p));
        chk({tag, ".timeout"}, 64'(timeout_o),    64'(t));
        chk({tag, ".testnum"}, testnum_o,         tn);
        chk({tag, ".cycles"},  cycle_cnt_o,       cnt);
    endtask

    task automatic step(input logic req, input logic we, input logic [63:0] addr,
                        input logic [63:0] wdata);
        bus.req_i   = req;
        bus.we_i    = we;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        @(posedge clk);
        @(negedge clk);
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 64'd0, 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst         = 1'b1;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = 64'd0;
        bus.wdata_i = 64'd0;
        repeat (2) @(negedge clk);
        chk_all({tag, ".reset"}, 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        rst = 1'b0;
    endtask

    initial begin
        // req we addr wdata | rvalid rdata done pass tmo testnum cycles
        vecs.push_back(mk(1, 1, TN,  64'h11, 0, 64'h0,  0, 0, 0, 64'h11, 0));
        vecs.push_back(mk(0, 0, 0,   0,      0, 64'h0,  0, 0, 0, 64'h11, 1));
        vecs.push_back(mk(0, 0, 0,   0,      0, 64'h0,  0, 0, 0, 64'h11, 2));
        vecs.push_back(mk(0, 0, 0,   0,      0, 64'h0,  0, 0, 0, 64'h11, 3));
        vecs.push_back(mk(0, 0, 0,   0,      0, 64'h0,  0, 0, 0, 64'h11, 4));
        vecs.push_back(mk(1, 1, TN,  64'h7,  0, 64'h0,  0, 0, 0, 64'h7,  5));
        vecs.push_back(mk(1, 0, ST,  0,      1, 64'h1,  0, 0, 0, 64'h7,  6));
        vecs.push_back(mk(1, 0, CYC, 0,      1, 64'h6,  0, 0, 0, 64'h7,  7));
        vecs.push_back(mk(1, 1, RES, 64'h3,  0, 64'h6,  1, 1, 0, 64'h7,  8));
        vecs.push_back(mk(1, 0, ST,  0,      1, 64'hE,  1, 1, 0, 64'h7,  8));
        vecs.push_back(mk(1, 1, TN,  64'h99, 0, 64'hE,  1, 1, 0, 64'h7,  8));
        vecs.push_back(mk(1, 1, RES, 64'h0,  0, 64'hE,  1, 1, 0, 64'h7,  8));
        vecs.push_back(mk(1, 0, B + 64'h5, 0, 1, 64'h7, 1, 1, 0, 64'h7,  8));
        vecs.push_back(mk(1, 0, CYC, 0,      1, 64'h8,  1, 1, 0, 64'h7,  8));
        vecs.push_back(mk(1, 0, B + 64'h40, 0, 1, 64'h0, 1, 1, 0, 64'h7, 8));
        vecs.push_back(mk(1, 0, TN,  0,      1, 64'h7,  1, 1, 0, 64'h7,  8));
        vecs.push_back(mk(1, 0, RES, 0,      1, 64'h0,  1, 1, 0, 64'h7,  8));
        vecs.push_back(mk(1, 0, ST,  0,      1, 64'hE,  1, 1, 0, 64'h7,  8));
        vecs.push_back(mk(1, 0, B - 64'h8, 0, 1, 64'h0, 1, 1, 0, 64'h7,  8));

        do_reset("tbl");
        foreach (vecs[i]) begin
            step(vecs[i].req, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk_all($sformatf("vec%0d", i), vecs[i].rvalid, vecs[i].rdata, vecs[i].done,
                    vecs[i].pass, vecs[i].tmo, vecs[i].tn, vecs[i].cnt);
        end

        // Fail result is sticky; IDLE and out-of-window writes are ignored.
        do_reset("fail");
        step(1, 1, RES, 64'h1);
        chk("idle_result.done", 64'(done_o), 64'd0);
        step(1, 1, TN, 64'h3);
        step(1, 1, B + 64'h20, 64'h55);
        chk("oob_write.testnum", testnum_o, 64'h3);
        step(1, 1, B + 64'h28, 64'h1);
        chk("oob_result.done", 64'(done_o), 64'd0);
        step(1, 1, RES, 64'h0);
        chk_all("fail_res0", 1'b0, 64'd0, 1'b1, 1'b0, 1'b0, 64'h3, 64'd4);
        step(1, 1, RES, 64'h1);
        step(1, 1, TN, 64'h5);
        step(1, 0, ST, 64'd0);
        chk_all("fail_sticky", 1'b1, 64'h7, 1'b1, 1'b0, 1'b0, 64'h3, 64'd4);

        // Watchdog expiry after the tenth RUN cycle.
        do_reset("wd");
        idle(10);
        chk_all("wd_before", 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd9);
        idle(1);
        chk_all("wd_expire", 1'b0, 64'd0, 1'b1, 1'b0, 1'b1, 64'd0, 64'd10);
        step(1, 0, CYC, 64'd0);
        chk("wd_cycles_read", bus.rdata_o, 64'd10);
        step(1, 0, ST, 64'd0);
        chk("wd_status_read", bus.rdata_o, 64'h17);
        idle(3);
        chk("wd_frozen.cycles", cycle_cnt_o, 64'd10);

        // Result write on the expiry edge beats the watchdog.
        do_reset("race");
        idle(10);
        step(1, 1, RES, 64'h1);
        chk_all("race", 1'b0, 64'd0, 1'b1, 1'b1, 1'b0, 64'd0, 64'd10);
        step(1, 0, ST, 64'd0);
        chk("race_status", bus.rdata_o, 64'hE);

        // Asynchronous reset mid-low-phase clears sticky state without a clock edge.
        #2 rst = 1'b1;
        #1;
        chk_all("async_rst", 1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
